// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter that drives a shared 4:1 word mux into a registered valid/ready output stage.
// Optional owner locking is compiled in with `define MUX4_ARB_LOCK_EN (adds the lock input port).
module mux4_rr_arbiter #(
  parameter int BIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [BIT-1:0] din0,
  input  logic [BIT-1:0] din1,
  input  logic [BIT-1:0] din2,
  input  logic [BIT-1:0] din3,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [3:0]     lock,
`endif
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic [BIT-1:0] dout,
  output logic           dout_valid,
  input  logic           dout_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [BIT-1:0] dout_q, dout_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     ptr_q, ptr_d;

  logic [BIT-1:0] din_arr [4];
  logic [3:0]     req_eff;
  logic [1:0]     winner;
  logic [1:0]     idx;
  logic           found;
  logic           load;

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;

`ifdef MUX4_ARB_LOCK_EN
  logic       locked_q, locked_d;
  logic [1:0] owner_q, owner_d;

  // While locked, only the owner's request is visible to the search.
  assign req_eff = locked_q ? (req & (4'b0001 << owner_q)) : req;
`else
  assign req_eff = req;
`endif

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign load = (|req_eff) && ((state_q == IDLE) || dout_ready);
  assign gnt  = (load && !rst) ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
`ifdef MUX4_ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    if (load) begin
      state_d = BUSY;
      dout_d  = din_arr[winner];
      sel_d   = winner;
      ptr_d   = winner + 2'd1;
`ifdef MUX4_ARB_LOCK_EN
      if (lock[winner]) begin
        locked_d = 1'b1;
        owner_d  = winner;
        ptr_d    = ptr_q;
      end else begin
        locked_d = 1'b0;
      end
`endif
    end else if (state_q == BUSY && dout_ready) begin
      state_d = IDLE;
`ifdef MUX4_ARB_LOCK_EN
      // Owner's word drained with no follow-up request: release the lock.
      if (locked_q && !req[owner_q]) begin
        locked_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      sel_q    <= 2'd0;
      ptr_q    <= 2'd0;
`ifdef MUX4_ARB_LOCK_EN
      locked_q <= 1'b0;
      owner_q  <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
`ifdef MUX4_ARB_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign sel        = sel_q;
  assign dout_valid = (state_q == BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter with hand-computed expectations.
// Lock vectors are compiled only when MUX4_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din0 = 4'h0, din1 = 4'h0, din2 = 4'h0, din3 = 4'h0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
  logic [3:0] lock = 4'b0000;
`endif

  int n_vec = 0;
  int n_err = 0;

  mux4_rr_arbiter #(.BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
`ifdef MUX4_ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state, with requests present to show gnt is masked during rst.
    req = 4'b1111;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    req = 4'b0000;
    rst = 1'b0;
    #1;
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single request from source 2.
    req = 4'b0100; din2 = 4'hA; dout_ready = 1'b1;
    #1;
    check("single_gnt", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0000;
    check("single_dout", 32'(dout), 32'hA);
    check("single_sel", 32'(sel), 32'd2);
    check("single_valid", 32'(dout_valid), 32'h1);
    #1;
    check("drain_gnt", 32'(gnt), 32'h0);
    tick();
    check("drain_valid", 32'(dout_valid), 32'h0);
    check("drain_dout_hold", 32'(dout), 32'hA);

    // dout_ready while idle changes nothing.
    tick();
    check("idle_ready_valid", 32'(dout_valid), 32'h0);

    // All four requesting: rotation 0,1,2,3,0 from a fresh pointer.
    do_reset();
    din0 = 4'h0; din1 = 4'h1; din2 = 4'h2; din3 = 4'h3;
    req = 4'b1111; dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      #1;
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g));
      tick();
      check($sformatf("rr_dout%0d", k), 32'(dout), 32'(k % 4));
      check($sformatf("rr_sel%0d", k), 32'(sel), 32'(k % 4));
    end

    // Pointer is now 1: grant 1, then 0011 must wrap to 0.
    req = 4'b0010; din0 = 4'h5;
    #1;
    check("fair_gnt1", 32'(gnt), 32'b0010);
    tick();
    req = 4'b0011;
    #1;
    check("fair_gnt0", 32'(gnt), 32'b0001);
    tick();
    check("fair_dout", 32'(dout), 32'h5);

    // Backpressure: three stalled cycles with requests pending.
    dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_gnt%0d", k), 32'(gnt), 32'h0);
      tick();
      check($sformatf("bp_dout%0d", k), 32'(dout), 32'h5);
      check($sformatf("bp_sel%0d", k), 32'(sel), 32'h0);
      check($sformatf("bp_valid%0d", k), 32'(dout_valid), 32'h1);
    end
    // Release: immediate back-to-back reload from source 1 (pointer 1).
    dout_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(gnt), 32'b0010);
    tick();
    check("bp_release_dout", 32'(dout), 32'h1);
    check("bp_release_valid", 32'(dout_valid), 32'h1);

    // Asynchronous reset mid-transfer, pointer was 2.
    req = 4'b1000; dout_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(dout_valid), 32'h0);
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_dout", 32'(dout), 32'h0);
    tick();
    rst = 1'b0;
    req = 4'b1010; dout_ready = 1'b1;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    tick();
    check("post_rst_sel", 32'(sel), 32'h1);
    check("post_rst_dout", 32'(dout), 32'h1);
    req = 4'b0000;
    tick();

`ifdef MUX4_ARB_LOCK_EN
    // Lock on source 1 holds off source 2 until the lock drops.
    do_reset();
    req = 4'b0110; lock = 4'b0010; dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lock_gnt%0d", k), 32'(gnt), 32'b0010);
      tick();
    end
    lock = 4'b0000;
    #1;
    check("unlock_gnt_owner", 32'(gnt), 32'b0010);
    tick();
    #1;
    check("unlock_gnt_next", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0000;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
